mmio_bridge: RTL and testbench

MMIO_BRIDGE -- requirements
Module: mmio_bridge

---
 rtl/mmio_bridge.sv | 154 +++++++++++++++
 tb/tb_mmio_bridge.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mmio_bridge.sv
// Memory-mapped I/O bridge: splits CPU data-port accesses between external RAM and
// LED/switch/button registers. Optional button debounce is enabled by MMIO_BTN_DEBOUNCE_EN.
module mmio_bridge #(
  parameter int               WORD       = 9,
  parameter int               ADDR       = 11,
  parameter logic [ADDR-1:0]  IO_BASE    = 11'h7F8,
  parameter int               N_LED      = 8,
  parameter int               N_SW       = 8,
  parameter int               N_BTN      = 5,
  parameter logic [N_LED-1:0] LED_INIT   = 8'b10011001,
  parameter int               DEB_CYCLES = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [ADDR-1:0]  i_addr,
  input  logic [WORD-1:0]  i_wdata,
  output logic [WORD-1:0]  o_rdata,
  output logic             o_ram_en,
  output logic             o_ram_we,
  output logic             o_ram_re,
  output logic [ADDR-1:0]  o_ram_addr,
  output logic [WORD-1:0]  o_ram_data,
  input  logic [WORD-1:0]  i_ram_data,
  output logic [N_LED-1:0] o_led,
  input  logic [N_SW-1:0]  i_sw,
  input  logic [N_BTN-1:0] i_btn
);

  localparam logic [ADDR-1:0] OFF_LED = ADDR'(0);
  localparam logic [ADDR-1:0] OFF_SW  = ADDR'(1);
  localparam logic [ADDR-1:0] OFF_LVL = ADDR'(2);
  localparam logic [ADDR-1:0] OFF_EVT = ADDR'(3);

  if (N_LED > WORD || N_SW > WORD || N_BTN > WORD || DEB_CYCLES < 1) begin : g_param_err
    $error("mmio_bridge: register widths must fit WORD and DEB_CYCLES must be >= 1");
  end

  logic             is_io;
  logic [ADDR-1:0]  off;
  logic             acc_wr;
  logic             acc_rd;
  logic [N_LED-1:0] led_q;
  logic [N_SW-1:0]  sw_s1, sw_s2;
  logic [N_BTN-1:0] btn_s1, btn_s2;
  logic [N_BTN-1:0] btn_lvl;
  logic [N_BTN-1:0] btn_prev;
  logic [N_BTN-1:0] btn_evt;
  logic [N_BTN-1:0] evt_clr;
  logic [WORD-1:0]  io_val;
  logic             sel_ram_p1;
  logic [WORD-1:0]  rdata_p1;

  // Stage p0: address decode and RAM pass-through
  assign is_io      = (i_addr >= IO_BASE);
  assign off        = i_addr - IO_BASE;
  assign acc_wr     = i_en & i_we;
  assign acc_rd     = i_en & i_re;
  assign o_ram_en   = i_en & ~is_io;
  assign o_ram_we   = i_en & i_we & ~is_io;
  assign o_ram_re   = i_en & i_re & ~is_io;
  assign o_ram_addr = i_addr;
  assign o_ram_data = i_wdata;
  assign o_led      = led_q;

  always_comb begin
    io_val = '0;
    if (is_io) begin
      if (off == OFF_LED)      io_val = WORD'(led_q);
      else if (off == OFF_SW)  io_val = WORD'(sw_s2);
      else if (off == OFF_LVL) io_val = WORD'(btn_lvl);
      else if (off == OFF_EVT) io_val = WORD'(btn_evt);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      led_q <= LED_INIT;
    end else if (acc_wr && is_io && off == OFF_LED) begin
      led_q <= i_wdata[N_LED-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      sw_s1  <= i_sw;
      sw_s2  <= sw_s1;
      btn_s1 <= i_btn;
      btn_s2 <= btn_s1;
    end
  end

`ifdef MMIO_BTN_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  logic [CNT_W-1:0] deb_cnt [N_BTN];

  // Each counter runs only while its input disagrees with the level; any agreement restarts it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      btn_lvl <= '0;
      for (int k = 0; k < N_BTN; k++) deb_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < N_BTN; k++) begin
        if (btn_s2[k] != btn_lvl[k]) begin
          if (deb_cnt[k] == CNT_W'(DEB_CYCLES - 1)) begin
            btn_lvl[k] <= btn_s2[k];
            deb_cnt[k] <= '0;
          end else begin
            deb_cnt[k] <= deb_cnt[k] + 1'b1;
          end
        end else begin
          deb_cnt[k] <= '0;
        end
      end
    end
  end
`else
  assign btn_lvl = btn_s2;
`endif

  // Set has priority over a same-cycle write-1-to-clear.
  assign evt_clr = (acc_wr && is_io && off == OFF_EVT) ? i_wdata[N_BTN-1:0] : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      btn_prev <= '0;
      btn_evt  <= '0;
    end else begin
      btn_prev <= btn_lvl;
      btn_evt  <= (btn_evt & ~evt_clr) | (btn_lvl & ~btn_prev);
    end
  end

  // Stage p1: registered read data and region select
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sel_ram_p1 <= 1'b0;
      rdata_p1   <= '0;
    end else if (acc_rd) begin
      sel_ram_p1 <= ~is_io;
      rdata_p1   <= io_val;
    end
  end

  assign o_rdata = sel_ram_p1 ? i_ram_data : rdata_p1;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge: read results are queued when a read is issued and
// compared one cycle later against the DUT read data.
module tb_mmio_bridge;
  localparam logic [10:0] IO = 11'h7F8;

  logic        clk = 1'b0;
  logic        rst, en, we, re;
  logic [10:0] addr;
  logic [8:0]  wdata, rdata;
  logic        ram_en, ram_we, ram_re;
  logic [10:0] ram_addr;
  logic [8:0]  ram_wdata, ram_rdata;
  logic [7:0]  led, sw;
  logic [4:0]  btn;

  logic [8:0]  mem [0:2047];
  logic [8:0]  ram_q;

  logic [8:0]  exp_q [$];
  string       tag_q [$];
  int          n_assert = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  mmio_bridge dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_we(we), .i_re(re),
    .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata),
    .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_re(ram_re),
    .o_ram_addr(ram_addr), .o_ram_data(ram_wdata), .i_ram_data(ram_rdata),
    .o_led(led), .i_sw(sw), .i_btn(btn)
  );

  // Synchronous RAM with a one-cycle read
  always @(posedge clk) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_en && ram_re) ram_q <= mem[ram_addr];
  end
  assign ram_rdata = ram_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; we = 1'b0; re = 1'b0;
  endtask

  task automatic wr(input logic [10:0] a, input logic [8:0] d);
    en = 1'b1; we = 1'b1; re = 1'b0; addr = a; wdata = d;
    cyc();
    idle();
  endtask

  task automatic rd(input logic [10:0] a, input logic [8:0] exp, input string tag);
    en = 1'b1; re = 1'b1; we = 1'b0; addr = a;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    cyc();
    idle();
    @(negedge clk);
    chk(tag_q.pop_front(), rdata, exp_q.pop_front());
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst = 1'b1; en = 1'b0; we = 1'b0; re = 1'b0;
    addr = '0; wdata = '0; sw = '0; btn = '0;
    repeat (3) cyc();
    chk("rst_led", led, 8'b10011001);
    chk("rst_rdata", rdata, 9'h000);
    rst = 1'b0;
    cyc();

    // LED write: RAM strobes stay low, value lands on the next edge
    en = 1'b1; we = 1'b1; addr = IO; wdata = 9'h055;
    #1;
    chk("io_wr_ram_en", ram_en, 1'b0);
    chk("io_wr_ram_we", ram_we, 1'b0);
    chk("led_before_edge", led, 8'b10011001);
    cyc();
    idle();
    chk("led_write", led, 8'h55);
    rd(IO, 9'h055, "led_read");

    // RAM write and read-back
    en = 1'b1; we = 1'b1; addr = 11'h010; wdata = 9'h1A3;
    #1;
    chk("ram_we_pulse", ram_we, 1'b1);
    chk("ram_en_on", ram_en, 1'b1);
    chk("ram_addr", ram_addr, 11'h010);
    chk("ram_data", ram_wdata, 9'h1A3);
    cyc();
    idle();
    #1;
    chk("ram_we_drop", ram_we, 1'b0);
    rd(11'h010, 9'h1A3, "ram_read");
    repeat (2) cyc();
    chk("ram_rdata_hold", rdata, 9'h1A3);

    // Switches, unmapped offset, read-only writes
    sw = 8'hC3;
    repeat (3) cyc();
    rd(IO + 11'd1, 9'h0C3, "sw_read");
    rd(IO + 11'd5, 9'h000, "unmapped_read");
    wr(IO + 11'd1, 9'h1FF);
    rd(IO + 11'd1, 9'h0C3, "sw_ro");
    wr(IO + 11'd5, 9'h1FF);
    rd(IO, 9'h055, "unmapped_wr_ignored");

`ifdef MMIO_BTN_DEBOUNCE_EN
    for (int i = 0; i < 8; i++) begin
      btn[0] = ~btn[0];
      repeat (5) cyc();
    end
    rd(IO + 11'd2, 9'h000, "bounce_lvl");
    btn[0] = 1'b1;
    repeat (10) cyc();
    rd(IO + 11'd2, 9'h000, "deb_lvl_early");
    repeat (10) cyc();
    rd(IO + 11'd2, 9'h001, "deb_lvl_set");
    rd(IO + 11'd3, 9'h001, "deb_evt_set");
`else
    btn[2] = 1'b1;
    cyc();
    cyc();
    rd(IO + 11'd3, 9'h000, "evt_not_yet");
    rd(IO + 11'd3, 9'h004, "evt_set");
    rd(IO + 11'd2, 9'h004, "btn_lvl");
    wr(IO + 11'd2, 9'h000);
    rd(IO + 11'd2, 9'h004, "lvl_ro");
    wr(IO + 11'd3, 9'h004);
    rd(IO + 11'd3, 9'h000, "evt_clear");
    btn[2] = 1'b0;
    repeat (4) cyc();
    btn[2] = 1'b1;
    cyc();
    cyc();
    wr(IO + 11'd3, 9'h004);
    rd(IO + 11'd3, 9'h004, "set_beats_clear");
`endif

    // Simultaneous read and write of LED returns the old value
    en = 1'b1; we = 1'b1; re = 1'b1; addr = IO; wdata = 9'h0AA;
    exp_q.push_back(9'h055);
    tag_q.push_back("rw_same_reg");
    cyc();
    idle();
    @(negedge clk);
    chk(tag_q.pop_front(), rdata, exp_q.pop_front());
    chk("rw_led_new", led, 8'hAA);
    cyc();

    // Strobes without enable are ignored
    en = 1'b0; we = 1'b1; re = 1'b1; addr = IO; wdata = 9'h000;
    cyc();
    idle();
    chk("no_en_led", led, 8'hAA);

    // Reset lands between a read request and its data, with a write in flight
    en = 1'b1; re = 1'b1; addr = IO;
    cyc();
    rst = 1'b1; en = 1'b1; we = 1'b1; re = 1'b0; addr = IO; wdata = 9'h00F;
    cyc();
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("rst_mid_rdata", rdata, 9'h000);
    chk("rst_mid_led", led, 8'b10011001);
    rd(IO + 11'd3, 9'h000, "rst_mid_evt");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
